// File: rtl/inst_mem_pkg.sv
// Shared types and default sizes for the instruction memory fetch block.
// Contents: FSM state enum, default width constants, and the response sideband
// struct (fault plus optional parity error). The top pairs this sideband with a
// DATA_W-wide data field to form its response word.
// Optional feature macro: INST_MEM_PARITY_EN adds the perr sideband bit.
package inst_mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DEPTH  = 256;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Response sideband; data is prepended by the top at its own DATA_W.
  typedef struct packed {
    logic fault;
`ifdef INST_MEM_PARITY_EN
    logic perr;
`endif
  } resp_meta_t;

endpackage

// File: rtl/inst_mem_fetch_if.sv
// Fetch request/response bus between the fetch stage and the instruction memory.
// Signals: req_valid/req_ready/req_addr (request), resp_valid/resp_ready/
// resp_data/resp_fault (response), resp_perr when INST_MEM_PARITY_EN is defined.
// Modports: master = fetch stage / consumer, slave = instruction memory.
interface inst_mem_fetch_if import inst_mem_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_fault;
`ifdef INST_MEM_PARITY_EN
  logic              resp_perr;
`endif

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_fault
`ifdef INST_MEM_PARITY_EN
    , input resp_perr
`endif
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_fault
`ifdef INST_MEM_PARITY_EN
    , output resp_perr
`endif
  );

endinterface

// File: rtl/resp_skid_fifo.sv
// Two-entry fall-through response FIFO.
// Ports: clk, reset (sync, active-high), push/push_data (write), pop (read, only
// while valid_c), head_c/valid_c (combinational head; bypasses push_data when
// empty), count (registered occupancy 0..2).
module resp_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         valid_c,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         wr_c;
  logic         rd_c;

  // An empty FIFO presents the incoming word directly so the first response
  // appears in the cycle its read data lands.
  assign valid_c = (count != 2'd0) || push;
  assign head_c  = (count == 2'd0) ? push_data : e0;
  assign rd_c    = pop && (count != 2'd0);
  assign wr_c    = push && !(pop && (count == 2'd0));

  // Storage and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({wr_c, rd_c})
        2'b10: begin
          if (count == 2'd0) e0 <= push_data;
          else               e1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Synchronous-read instruction memory with a boot-time loader and a valid/ready
// fetch port. LOAD state fills the array through an auto-incrementing pointer;
// load_done moves to RUN, where fetches are served with a one-cycle registered
// read into a two-entry response buffer.
// Ports: clk, reset (sync, active-high), load_wr_en/load_data/load_done (loader),
// load_wrap (sticky pointer wrap), run (RUN state), fetch (inst_mem_fetch_if.slave).
// Optional feature macro: INST_MEM_PARITY_EN stores an even-parity bit per word
// and reports mismatches on fetch.resp_perr.
module inst_mem_fetch import inst_mem_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_wr_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_wrap,
  output logic              run,
  inst_mem_fetch_if.slave   fetch
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    resp_meta_t        meta;
  } resp_t;

  localparam int unsigned RESP_W = $bits(resp_t);

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef INST_MEM_PARITY_EN
  logic              par [DEPTH];
`endif

  state_t            state;
  logic [IDX_W-1:0]  load_ptr;
  logic              inflight;
  resp_t             rd_resp;
  resp_t             buf_head_c;
  logic              buf_valid_c;
  logic [1:0]        buf_count;
  logic              in_range_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              accept_c;
  logic              pop_c;

  assign in_range_c = {1'b0, fetch.req_addr} < CMP_W'(DEPTH);
  assign rd_idx_c   = fetch.req_addr[IDX_W-1:0];

  // Outstanding work (buffered plus the read in flight) never exceeds the buffer.
  assign fetch.req_ready = run && ((3'(buf_count) + 3'(inflight)) < 3'd2);
  assign accept_c        = fetch.req_valid && fetch.req_ready;
  assign pop_c           = fetch.resp_ready && buf_valid_c;

  // Loader writes; array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_LOAD) && load_wr_en) begin
      mem[load_ptr] <= load_data;
`ifdef INST_MEM_PARITY_EN
      par[load_ptr] <= ^load_data;
`endif
    end
  end

  // FSM, load pointer and registered read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      run       <= 1'b0;
      load_ptr  <= '0;
      load_wrap <= 1'b0;
      inflight  <= 1'b0;
      rd_resp   <= '0;
    end else begin
      inflight <= accept_c;
      if (accept_c) begin
        rd_resp.data       <= in_range_c ? mem[rd_idx_c] : '0;
        rd_resp.meta.fault <= !in_range_c;
`ifdef INST_MEM_PARITY_EN
        rd_resp.meta.perr  <= in_range_c && ((^mem[rd_idx_c]) != par[rd_idx_c]);
`endif
      end
      if (state == ST_LOAD) begin
        if (load_wr_en) begin
          if (load_ptr == IDX_W'(DEPTH - 1)) begin
            load_ptr  <= '0;
            load_wrap <= 1'b1;
          end else begin
            load_ptr  <= load_ptr + IDX_W'(1);
          end
        end
        if (load_done) begin
          state <= ST_RUN;
          run   <= 1'b1;
        end
      end
    end
  end

  resp_skid_fifo #(
    .W (RESP_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (rd_resp),
    .pop       (pop_c),
    .head_c    (buf_head_c),
    .valid_c   (buf_valid_c),
    .count     (buf_count)
  );

  assign fetch.resp_valid = buf_valid_c;
  assign fetch.resp_data  = buf_head_c.data;
  assign fetch.resp_fault = buf_head_c.meta.fault;
`ifdef INST_MEM_PARITY_EN
  assign fetch.resp_perr  = buf_head_c.meta.perr;
`endif

endmodule
